// File: rtl/gate_scan_display.sv
// Channel selector and LED driver for the gate test harness: picks one of CHANNELS
// packed results by manual switch, timed scan, debounced button step, or freeze.
module gate_scan_display #(
  parameter int CHANNELS       = 16,
  parameter int WIDTH          = 8,
  parameter int SEL_W          = 4,
  parameter int SCAN_TICKS     = 50_000_000,
  parameter int DEBOUNCE_TICKS = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] ch_data,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      step_btn,
  output logic [WIDTH-1:0]          led,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      scan_wrap
);
  localparam int SC_W = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
  localparam int DB_W = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  typedef enum logic [1:0] {MANUAL = 2'b00, AUTO = 2'b01, STEP = 2'b10, HOLD = 2'b11} state_t;

  logic [1:0]       mode_s1, mode_s2;
  logic [SEL_W-1:0] sel_s1, sel_s2;
  logic             btn_s1, btn_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1 <= '0; mode_s2 <= '0;
      sel_s1  <= '0; sel_s2  <= '0;
      btn_s1  <= 1'b0; btn_s2 <= 1'b0;
    end else begin
      mode_s1 <= mode;     mode_s2 <= mode_s1;
      sel_s1  <= sel_in;   sel_s2  <= sel_s1;
      btn_s1  <= step_btn; btn_s2  <= btn_s1;
    end
  end

  // Debounced level only flips after DEBOUNCE_TICKS consecutive differing samples.
  logic            db_lvl, db_prev, step_pulse;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_lvl  <= 1'b0;
      db_prev <= 1'b0;
      db_cnt  <= '0;
    end else begin
      db_prev <= db_lvl;
      if (btn_s2 != db_lvl) begin
        if (db_cnt == DB_W'(DEBOUNCE_TICKS - 1)) begin
          db_lvl <= btn_s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign step_pulse = db_lvl & ~db_prev;

  // Pad the channel table to the full select range so any index is safe.
  logic [2**SEL_W-1:0][WIDTH-1:0] ch_arr;
  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_ch
    if (k < CHANNELS) begin : g_used
      assign ch_arr[k] = ch_data[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch_arr[k] = '0;
    end
  end

  state_t           state, state_nxt;
  logic [SEL_W-1:0] cur_nxt, sel_clamp;
  logic [SC_W-1:0]  scan_cnt, scan_nxt;
  logic             wrap_nxt, adv;

  assign sel_clamp = (int'(sel_s2) >= CHANNELS) ? LAST : sel_s2;

  always_comb begin
    state_nxt = state_t'(mode_s2);
    cur_nxt   = cur_ch;
    scan_nxt  = scan_cnt;
    wrap_nxt  = 1'b0;
    adv       = 1'b0;
    case (state)
      MANUAL: begin
        cur_nxt  = sel_clamp;
        scan_nxt = '0;
      end
      AUTO: begin
        if (scan_cnt == SC_W'(SCAN_TICKS - 1)) begin
          adv      = 1'b1;
          scan_nxt = '0;
        end else begin
          scan_nxt = scan_cnt + SC_W'(1);
        end
      end
      STEP: begin
        adv      = step_pulse;
        scan_nxt = '0;
      end
      default: begin
        // Frozen while held; a fresh scan period starts on the way out.
        if (state_nxt != HOLD) scan_nxt = '0;
      end
    endcase
    if (adv) begin
      wrap_nxt = (cur_ch == LAST);
      cur_nxt  = wrap_nxt ? '0 : cur_ch + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MANUAL;
      cur_ch    <= '0;
      scan_cnt  <= '0;
      scan_wrap <= 1'b0;
      led       <= '0;
    end else begin
      state     <= state_nxt;
      cur_ch    <= cur_nxt;
      scan_cnt  <= scan_nxt;
      scan_wrap <= wrap_nxt;
      if (state != HOLD) led <= ch_arr[cur_ch];
    end
  end
endmodule

// File: doc/gate_scan_display.md
# gate_scan_display

Parametrised channel selector and LED display driver for the board-level gate test harness. It takes the packed outputs of CHANNELS gate-under-test instances and presents one channel at a time on the WIDTH-bit LED bank. The channel is chosen by one of four modes:

- manual select from switches
- timed auto-scan
- debounced push-button stepping
- freeze

This replaces the hard-wired 16-way switch case in the top level with one registered block reusable across board revisions.

## Interface

Parameters:
- CHANNELS, 16, number of input channels (≥2, need not be a power of two)
- WIDTH, 8, bits per channel and LED width
- SEL_W, 4, select/index width; must satisfy 2^SEL_W ≥ CHANNELS
- SCAN_TICKS, 50_000_000, clk cycles per channel in auto mode (≥2)
- DEBOUNCE_TICKS, 1_000_000, stable cycles required to accept a button level change (≥2)

Ports:
- clk  input  1  system clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- ch_data  input  CHANNELS*WIDTH  packed channel results; channel k occupies [k*WIDTH +: WIDTH]; treated as synchronous to clk
- mode  input  2  raw switches: 00 MANUAL, 01 AUTO, 10 STEP, 11 HOLD
- sel_in  input  SEL_W  raw switches, channel index for MANUAL
- step_btn  input  1  raw push button, active high, asynchronous, bouncy
- led  output  WIDTH  registered display value
- cur_ch  output  SEL_W  registered index of the displayed channel
- scan_wrap  output  1  one-cycle pulse when cur_ch wraps from CHANNELS-1 to 0 in AUTO or STEP

## Operation

- Input synchronisation: mode, sel_in and step_btn each pass through a 2-flop synchroniser; all logic uses the synchronised copies only.
- Debouncer:
  - Counter runs while the synchronised step_btn differs from the debounced level.
  - The debounced level takes the new value when the count reaches DEBOUNCE_TICKS-1.
  - Any return to the debounced level clears the counter.
  - A rising edge of the debounced level produces step_pulse for one cycle.
- FSM states MANUAL, AUTO, STEP, HOLD. The state equals the synchronised mode, registered one cycle later; any state may go to any other.
- MANUAL: cur_ch <= synced sel_in, clamped to CHANNELS-1 when sel_in ≥ CHANNELS. step_pulse is ignored and the scan counter is held at 0.
- AUTO: the scan counter increments each cycle. At SCAN_TICKS-1 the counter clears and cur_ch advances by 1. On entering AUTO from any other state, the counter restarts at 0 and cur_ch keeps its value.
- STEP: each step_pulse advances cur_ch by 1. A step_pulse occurring in another state is discarded, not queued.
- Advance rule: CHANNELS-1 goes to 0 and asserts scan_wrap for that cycle; otherwise cur_ch increments.
- HOLD: cur_ch, led and the scan counter are frozen, and ch_data is ignored. Leaving HOLD resumes from the frozen cur_ch.
- led <= ch_data slice selected by cur_ch, every cycle except in HOLD.

## Timing

- Reset (rst_n low, asynchronous): the following clear immediately and stay cleared while rst_n is low:
  - led = 0, cur_ch = 0, scan_wrap = 0
  - state MANUAL
  - all synchroniser flops, counters and the debounced level
- Reset release mid-scan or mid-debounce: operation restarts from these values; no partial count survives.
- sel_in change to cur_ch: 3 cycles (2 synchroniser + 1 register). led follows cur_ch 1 cycle later, 4 cycles total.
- ch_data change to led: 1 cycle when the channel is already selected.
- mode change to new state: 3 cycles. The first AUTO advance happens SCAN_TICKS cycles after entering AUTO.
- Button press to cur_ch change: 2 (sync) + DEBOUNCE_TICKS + 1 cycles after the first stable edge.
- scan_wrap is high for exactly the cycle in which cur_ch is registered as 0 after wrapping.
- Mode change and advance in the same cycle: the state register update wins. An advance that was due in the old state on that cycle still occurs; the new state's behaviour applies from the next cycle.

## Test plan

Bench parameters: CHANNELS=5, WIDTH=8, SEL_W=3, SCAN_TICKS=4, DEBOUNCE_TICKS=3. ch_data channel k = 0x10+k unless stated.

- Reset: run AUTO for 10 cycles, drop rst_n asynchronously between edges -> led=0x00, cur_ch=0, scan_wrap=0 before the next edge; release -> MANUAL behaviour from sel_in.
- Manual and clamp: mode=00; set channel 2 = 0xA5, sel_in=2 -> cur_ch=2 at cycle 3, led=0xA5 at cycle 4; sel_in=7 -> cur_ch=4, led=0x14.
- Auto wrap: mode=01 from cur_ch=0 -> cur_ch steps 1,2,3,4,0 every 4 cycles; scan_wrap high for exactly one cycle with the 4->0 step, low otherwise.
- Debounce: step_btn glitch high for 2 cycles in STEP -> no change; held high for 6 cycles -> exactly one increment; bouncing release and re-press -> exactly one further increment.
- Hold: in AUTO at cur_ch=3, switch to 11 and change ch_data channel 3 to 0xFF -> led stays 0x13 and cur_ch stays 3; return to 01 -> next advance 4 cycles after state entry, led shows 0x14.
- Discarded step: mode=00, clean press -> cur_ch unchanged; switch to 10 with no press -> cur_ch unchanged.
